cdb_arbiter: RTL and testbench

Arbitrates the single common data bus (CDB) result broadcast among the four execution pipes fed by reservation-station dispatch: add ALU, mul, div and branch. Each pipe pushes completed results into a private FIFO with valid/ready handshake. One result per cycle is broadcast, oldest instruction first by `inst_num`, to the physical register file, reservation-station wakeup logic and ROB. The block supports a pipeline flush on branch mispredict.

---
 rtl/cdb_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
// Arbitrates the single common data bus among the four execution pipes
// (add ALU, mul, div, branch). Each pipe pushes completed results into a
// private circular FIFO. Each cycle the oldest buffered head, chosen by
// wrap-safe inst_num comparison, is broadcast on the registered CDB outputs.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   flush               : synchronous; drops all buffered results and the broadcast
//   <pipe>_valid        : pipe offers a result (pipe = add, mul, div, br)
//   <pipe>_ready        : FIFO can accept a result this cycle (registered count only)
//   <pipe>_phy_reg/_data/_inst_num : result fields
//   cdb_valid/_phy_reg/_data/_inst_num/_src : registered broadcast (src 0 add .. 3 br)

module cdb_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        add_valid,
  input  logic        mul_valid,
  input  logic        div_valid,
  input  logic        br_valid,
  output logic        add_ready,
  output logic        mul_ready,
  output logic        div_ready,
  output logic        br_ready,
  input  logic [7:0]  add_phy_reg,
  input  logic [7:0]  mul_phy_reg,
  input  logic [7:0]  div_phy_reg,
  input  logic [7:0]  br_phy_reg,
  input  logic [31:0] add_data,
  input  logic [31:0] mul_data,
  input  logic [31:0] div_data,
  input  logic [31:0] br_data,
  input  logic [31:0] add_inst_num,
  input  logic [31:0] mul_inst_num,
  input  logic [31:0] div_inst_num,
  input  logic [31:0] br_inst_num,
  output logic        cdb_valid,
  output logic [7:0]  cdb_phy_reg,
  output logic [31:0] cdb_data,
  output logic [31:0] cdb_inst_num,
  output logic [1:0]  cdb_src
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Requester inputs gathered into arrays indexed by cdb_src encoding.
  logic [3:0]  inValid;
  logic [7:0]  inPhy  [4];
  logic [31:0] inData [4];
  logic [31:0] inInst [4];

  assign inValid = {br_valid, div_valid, mul_valid, add_valid};
  assign inPhy[0]  = add_phy_reg;
  assign inPhy[1]  = mul_phy_reg;
  assign inPhy[2]  = div_phy_reg;
  assign inPhy[3]  = br_phy_reg;
  assign inData[0] = add_data;
  assign inData[1] = mul_data;
  assign inData[2] = div_data;
  assign inData[3] = br_data;
  assign inInst[0] = add_inst_num;
  assign inInst[1] = mul_inst_num;
  assign inInst[2] = div_inst_num;
  assign inInst[3] = br_inst_num;

  // FIFO state and storage.
  logic [PW-1:0] wrPtr_q [4];
  logic [PW-1:0] wrPtr_d [4];
  logic [PW-1:0] rdPtr_q [4];
  logic [PW-1:0] rdPtr_d [4];
  logic [CW-1:0] count_q [4];
  logic [CW-1:0] count_d [4];
  logic [7:0]    memPhy  [4][DEPTH];
  logic [31:0]   memData [4][DEPTH];
  logic [31:0]   memInst [4][DEPTH];

  // Broadcast registers.
  logic        cdbValid_q, cdbValid_d;
  logic [7:0]  cdbPhy_q, cdbPhy_d;
  logic [31:0] cdbData_q, cdbData_d;
  logic [31:0] cdbInst_q, cdbInst_d;
  logic [1:0]  cdbSrc_q, cdbSrc_d;

  logic [3:0]  ready;
  logic [3:0]  push;
  logic [3:0]  pop;
  logic [7:0]  headPhy  [4];
  logic [31:0] headData [4];
  logic [31:0] headInst [4];

  logic        winValid;
  logic [1:0]  winIdx;
  logic [31:0] winInst;
  logic signed [31:0] ageDiff;

  // Ready looks only at the registered count, so a full FIFO refuses a push
  // even when it is being popped on the same edge.
  always_comb begin
    ready = '0;
    push  = '0;
    for (int i = 0; i < 4; i++) begin
      ready[i]    = (count_q[i] < DEPTH_C);
      push[i]     = inValid[i] & ready[i] & ~flush;
      headPhy[i]  = memPhy[i][rdPtr_q[i]];
      headData[i] = memData[i][rdPtr_q[i]];
      headInst[i] = memInst[i][rdPtr_q[i]];
    end
  end

  assign add_ready = ready[0];
  assign mul_ready = ready[1];
  assign div_ready = ready[2];
  assign br_ready  = ready[3];

  // Oldest-first selection. Scanning br down to add and replacing only on a
  // strictly older tag makes equal tags resolve br > div > mul > add.
  // The signed difference keeps the compare correct across inst_num wrap.
  always_comb begin
    winValid = 1'b0;
    winIdx   = 2'd3;
    winInst  = '0;
    ageDiff  = '0;
    for (int i = 3; i >= 0; i--) begin
      if (count_q[i] != '0) begin
        ageDiff = $signed(headInst[i] - winInst);
        if (!winValid || (ageDiff < 0)) begin
          winValid = 1'b1;
          winIdx   = 2'(i);
          winInst  = headInst[i];
        end
      end
    end
  end

  // Pointer and count update; flush clears everything and suppresses both
  // pushes and the pop.
  always_comb begin
    pop = '0;
    for (int i = 0; i < 4; i++) begin
      pop[i]     = winValid & (winIdx == 2'(i)) & ~flush;
      wrPtr_d[i] = wrPtr_q[i];
      rdPtr_d[i] = rdPtr_q[i];
      count_d[i] = count_q[i];
      if (flush) begin
        wrPtr_d[i] = '0;
        rdPtr_d[i] = '0;
        count_d[i] = '0;
      end else begin
        if (push[i]) wrPtr_d[i] = wrPtr_q[i] + PW'(1);
        if (pop[i])  rdPtr_d[i] = rdPtr_q[i] + PW'(1);
        if (push[i] && !pop[i])      count_d[i] = count_q[i] + CW'(1);
        else if (!push[i] && pop[i]) count_d[i] = count_q[i] - CW'(1);
      end
    end
  end

  // Output fields load only on a real broadcast and otherwise hold.
  always_comb begin
    cdbValid_d = 1'b0;
    cdbPhy_d   = cdbPhy_q;
    cdbData_d  = cdbData_q;
    cdbInst_d  = cdbInst_q;
    cdbSrc_d   = cdbSrc_q;
    if (!flush && winValid) begin
      cdbValid_d = 1'b1;
      cdbPhy_d   = headPhy[winIdx];
      cdbData_d  = headData[winIdx];
      cdbInst_d  = headInst[winIdx];
      cdbSrc_d   = winIdx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wrPtr_q[i] <= '0;
        rdPtr_q[i] <= '0;
        count_q[i] <= '0;
      end
      cdbValid_q <= 1'b0;
      cdbPhy_q   <= '0;
      cdbData_q  <= '0;
      cdbInst_q  <= '0;
      cdbSrc_q   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        wrPtr_q[i] <= wrPtr_d[i];
        rdPtr_q[i] <= rdPtr_d[i];
        count_q[i] <= count_d[i];
      end
      cdbValid_q <= cdbValid_d;
      cdbPhy_q   <= cdbPhy_d;
      cdbData_q  <= cdbData_d;
      cdbInst_q  <= cdbInst_d;
      cdbSrc_q   <= cdbSrc_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they exist.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        memPhy[i][wrPtr_q[i]]  <= inPhy[i];
        memData[i][wrPtr_q[i]] <= inData[i];
        memInst[i][wrPtr_q[i]] <= inInst[i];
      end
    end
  end

  assign cdb_valid    = cdbValid_q;
  assign cdb_phy_reg  = cdbPhy_q;
  assign cdb_data     = cdbData_q;
  assign cdb_inst_num = cdbInst_q;
  assign cdb_src      = cdbSrc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
// Directed bench for cdb_arbiter (DEPTH=2): single push, contention, tie
// priority, backpressure, inst_num wrap, flush and async reset mid-stream.

module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        add_valid, mul_valid, div_valid, br_valid;
  logic        add_ready, mul_ready, div_ready, br_ready;
  logic [7:0]  add_phy_reg, mul_phy_reg, div_phy_reg, br_phy_reg;
  logic [31:0] add_data, mul_data, div_data, br_data;
  logic [31:0] add_inst_num, mul_inst_num, div_inst_num, br_inst_num;
  logic        cdb_valid;
  logic [7:0]  cdb_phy_reg;
  logic [31:0] cdb_data;
  logic [31:0] cdb_inst_num;
  logic [1:0]  cdb_src;

  int testsRun = 0;
  int testsFailed = 0;

  cdb_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .add_valid(add_valid), .mul_valid(mul_valid),
    .div_valid(div_valid), .br_valid(br_valid),
    .add_ready(add_ready), .mul_ready(mul_ready),
    .div_ready(div_ready), .br_ready(br_ready),
    .add_phy_reg(add_phy_reg), .mul_phy_reg(mul_phy_reg),
    .div_phy_reg(div_phy_reg), .br_phy_reg(br_phy_reg),
    .add_data(add_data), .mul_data(mul_data),
    .div_data(div_data), .br_data(br_data),
    .add_inst_num(add_inst_num), .mul_inst_num(mul_inst_num),
    .div_inst_num(div_inst_num), .br_inst_num(br_inst_num),
    .cdb_valid(cdb_valid), .cdb_phy_reg(cdb_phy_reg),
    .cdb_data(cdb_data), .cdb_inst_num(cdb_inst_num), .cdb_src(cdb_src)
  );

  always #5 clk = ~clk;

  // Drive one pipe's request (0 add, 1 mul, 2 div, 3 br).
  task automatic applyStimulus(input int pipe, input logic v, input logic [7:0] phy,
                               input logic [31:0] data, input logic [31:0] inst);
    case (pipe)
      0: begin add_valid = v; add_phy_reg = phy; add_data = data; add_inst_num = inst; end
      1: begin mul_valid = v; mul_phy_reg = phy; mul_data = data; mul_inst_num = inst; end
      2: begin div_valid = v; div_phy_reg = phy; div_data = data; div_inst_num = inst; end
      default: begin br_valid = v; br_phy_reg = phy; br_data = data; br_inst_num = inst; end
    endcase
  endtask

  task automatic clearValids();
    add_valid = 1'b0; mul_valid = 1'b0; div_valid = 1'b0; br_valid = 1'b0;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Compare the broadcast; fields only matter when a broadcast is expected.
  task automatic checkOutput(input string tag, input logic expValid, input logic [7:0] expPhy,
                             input logic [31:0] expData, input logic [31:0] expInst,
                             input logic [1:0] expSrc);
    checkField({tag, ".valid"}, {31'd0, cdb_valid}, {31'd0, expValid});
    if (expValid) begin
      checkField({tag, ".phy"},  {24'd0, cdb_phy_reg}, {24'd0, expPhy});
      checkField({tag, ".data"}, cdb_data, expData);
      checkField({tag, ".inst"}, cdb_inst_num, expInst);
      checkField({tag, ".src"},  {30'd0, cdb_src}, {30'd0, expSrc});
    end
  endtask

  task automatic checkReadies(input string tag, input logic [3:0] exp);
    checkField(tag, {28'd0, br_ready, div_ready, mul_ready, add_ready}, {28'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    clearValids();
    for (int p = 0; p < 4; p++) applyStimulus(p, 1'b0, 8'h00, 32'h0, 32'h0);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    checkField("rst.valid", {31'd0, cdb_valid}, 32'd0);
    checkField("rst.phy",   {24'd0, cdb_phy_reg}, 32'd0);
    checkField("rst.data",  cdb_data, 32'd0);
    checkField("rst.inst",  cdb_inst_num, 32'd0);
    checkField("rst.src",   {30'd0, cdb_src}, 32'd0);
    reset = 1'b0;
    #1;
    checkReadies("rst.ready", 4'hF);

    // Single push: no bypass, broadcast one cycle later, then idle with hold
    applyStimulus(0, 1'b1, 8'h05, 32'h1234, 32'd10);
    tick();
    clearValids();
    checkOutput("single.nobypass", 1'b0, 8'h00, 32'h0, 32'h0, 2'd0);
    tick();
    checkOutput("single.bcast", 1'b1, 8'h05, 32'h1234, 32'd10, 2'd0);
    tick();
    checkOutput("single.idle", 1'b0, 8'h00, 32'h0, 32'h0, 2'd0);
    checkField("single.hold", cdb_data, 32'h1234);

    // Contention: div(3), mul(7), add(9)
    applyStimulus(1, 1'b1, 8'h11, 32'hAAAA0001, 32'd7);
    applyStimulus(2, 1'b1, 8'h12, 32'hAAAA0002, 32'd3);
    applyStimulus(0, 1'b1, 8'h13, 32'hAAAA0003, 32'd9);
    tick();
    clearValids();
    tick();
    checkOutput("cont.first", 1'b1, 8'h12, 32'hAAAA0002, 32'd3, 2'd2);
    tick();
    checkOutput("cont.second", 1'b1, 8'h11, 32'hAAAA0001, 32'd7, 2'd1);
    tick();
    checkOutput("cont.third", 1'b1, 8'h13, 32'hAAAA0003, 32'd9, 2'd0);
    tick();
    checkOutput("cont.idle", 1'b0, 8'h00, 32'h0, 32'h0, 2'd0);

    // Equal tags: br beats add
    applyStimulus(0, 1'b1, 8'h21, 32'h0000_00A0, 32'd50);
    applyStimulus(3, 1'b1, 8'h23, 32'h0000_00B0, 32'd50);
    tick();
    clearValids();
    tick();
    checkOutput("tie.br", 1'b1, 8'h23, 32'h0000_00B0, 32'd50, 2'd3);
    tick();
    checkOutput("tie.add", 1'b1, 8'h21, 32'h0000_00A0, 32'd50, 2'd0);
    tick();

    // Backpressure: add inst 0 hogs the bus while br pushes 100..102
    applyStimulus(0, 1'b1, 8'h30, 32'h0000_00A0, 32'd0);
    applyStimulus(3, 1'b1, 8'h40, 32'h0000_00B0, 32'd100);
    tick();
    checkReadies("bp.a1.ready", 4'hF);
    checkOutput("bp.a1", 1'b0, 8'h00, 32'h0, 32'h0, 2'd0);
    applyStimulus(3, 1'b1, 8'h41, 32'h0000_00B1, 32'd101);
    tick();
    checkReadies("bp.a2.ready", 4'h7);
    checkOutput("bp.a2", 1'b1, 8'h30, 32'h0000_00A0, 32'd0, 2'd0);
    applyStimulus(3, 1'b1, 8'h42, 32'h0000_00B2, 32'd102);
    tick();
    checkReadies("bp.a3.ready", 4'h7);
    checkOutput("bp.a3", 1'b1, 8'h30, 32'h0000_00A0, 32'd0, 2'd0);
    tick();
    checkReadies("bp.a4.ready", 4'h7);
    add_valid = 1'b0;
    tick();
    checkReadies("bp.a5.ready", 4'h7);
    checkOutput("bp.a5", 1'b1, 8'h30, 32'h0000_00A0, 32'd0, 2'd0);
    tick();
    checkReadies("bp.a6.ready", 4'hF);
    checkOutput("bp.br0", 1'b1, 8'h40, 32'h0000_00B0, 32'd100, 2'd3);
    tick();
    clearValids();
    checkOutput("bp.br1", 1'b1, 8'h41, 32'h0000_00B1, 32'd101, 2'd3);
    tick();
    checkOutput("bp.br2", 1'b1, 8'h42, 32'h0000_00B2, 32'd102, 2'd3);
    tick();
    checkOutput("bp.idle", 1'b0, 8'h00, 32'h0, 32'h0, 2'd0);

    // Wrap: mul 0xFFFFFFFE is older than add 0x00000001
    applyStimulus(0, 1'b1, 8'h51, 32'h0000_0051, 32'h0000_0001);
    applyStimulus(1, 1'b1, 8'h52, 32'h0000_0052, 32'hFFFF_FFFE);
    tick();
    clearValids();
    tick();
    checkOutput("wrap.mul", 1'b1, 8'h52, 32'h0000_0052, 32'hFFFF_FFFE, 2'd1);
    tick();
    checkOutput("wrap.add", 1'b1, 8'h51, 32'h0000_0051, 32'h0000_0001, 2'd0);
    tick();

    // Flush with entries buffered in every FIFO and a same-edge add push
    for (int p = 0; p < 4; p++) applyStimulus(p, 1'b1, 8'h60, 32'h0000_0060, 32'(20 + p));
    tick();
    for (int p = 0; p < 4; p++) applyStimulus(p, 1'b1, 8'h61, 32'h0000_0061, 32'(24 + p));
    tick();
    checkOutput("flush.pre", 1'b1, 8'h60, 32'h0000_0060, 32'd20, 2'd0);
    clearValids();
    applyStimulus(0, 1'b1, 8'h62, 32'h0000_0062, 32'd28);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clearValids();
    checkOutput("flush.valid", 1'b0, 8'h00, 32'h0, 32'h0, 2'd0);
    checkReadies("flush.ready", 4'hF);
    tick();
    checkOutput("flush.after1", 1'b0, 8'h00, 32'h0, 32'h0, 2'd0);
    tick();
    checkOutput("flush.after2", 1'b0, 8'h00, 32'h0, 32'h0, 2'd0);
    applyStimulus(0, 1'b1, 8'h63, 32'h0000_0063, 32'd30);
    tick();
    clearValids();
    tick();
    checkOutput("flush.fresh", 1'b1, 8'h63, 32'h0000_0063, 32'd30, 2'd0);
    tick();
    checkOutput("flush.fresh.idle", 1'b0, 8'h00, 32'h0, 32'h0, 2'd0);

    // Async reset mid-stream with mul still buffered
    applyStimulus(0, 1'b1, 8'h70, 32'h0000_0070, 32'd40);
    applyStimulus(1, 1'b1, 8'h71, 32'h0000_0071, 32'd41);
    tick();
    clearValids();
    tick();
    checkOutput("areset.pre", 1'b1, 8'h70, 32'h0000_0070, 32'd40, 2'd0);
    #2;
    reset = 1'b1;
    #1;
    checkField("areset.valid", {31'd0, cdb_valid}, 32'd0);
    checkField("areset.inst",  cdb_inst_num, 32'd0);
    checkField("areset.src",   {30'd0, cdb_src}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    checkOutput("areset.after1", 1'b0, 8'h00, 32'h0, 32'h0, 2'd0);
    checkReadies("areset.ready", 4'hF);
    tick();
    checkOutput("areset.after2", 1'b0, 8'h00, 32'h0, 32'h0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
